// File: rtl/d7seg_pkg.sv
// Shared constants, font table and pin-polarity helpers for the 7-segment scan driver.
package d7seg_pkg;

   localparam int unsigned SEG_W      = 7;
   localparam int unsigned NUM_DIGITS = 4;
   localparam int unsigned NIB_W      = 4;
   localparam int unsigned IDX_W      = 2;
   localparam int unsigned DATA_W     = NUM_DIGITS * NIB_W;

   // Slot phase: blank gap for anti-ghosting, then the lit digit.
   typedef enum logic {
      PH_BLANK = 1'b0,
      PH_SHOW  = 1'b1
   } phase_e;

   // Active-high gfedcba patterns for hex digits 0..F.
   localparam logic [SEG_W-1:0] HEX_FONT [16] = '{
      7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
      7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
   };

   // Map an active-high segment pattern onto the pin polarity.
   function automatic logic [SEG_W-1:0] seg_drive(input logic [SEG_W-1:0] lit,
                                                  input logic              active_low);
      return active_low ? ~lit : lit;
   endfunction

   // Map an active-high digit-select vector onto the pin polarity.
   function automatic logic [NUM_DIGITS-1:0] dig_drive(input logic [NUM_DIGITS-1:0] sel,
                                                       input logic                  active_low);
      return active_low ? ~sel : sel;
   endfunction

endpackage

// File: rtl/d7seg_hex_decode.sv
// Nibble to active-high 7-segment pattern; blank forces all segments dark.
module d7seg_hex_decode
   import d7seg_pkg::*;
(
   input  logic [NIB_W-1:0] i_nibble,
   input  logic             i_blank,
   output logic [SEG_W-1:0] o_seg_c
);

   // Font lookup with blanking override.
   always_comb begin
      o_seg_c = '0;
      if (!i_blank) begin
         o_seg_c = HEX_FONT[i_nibble];
      end
   end

endmodule

// File: rtl/d7seg_scan_driver.sv
// Multiplexed 4-digit 7-segment scan driver: latches a frame of four hex
// nibbles, scans digits round-robin with a blank gap, drives seg/dig pins.
module d7seg_scan_driver
   import d7seg_pkg::*;
#(
   parameter int unsigned SCAN_DIV       = 50000,
   parameter int unsigned BLANK_CYCLES   = 500,
   parameter bit          SEG_ACTIVE_LOW = 1'b1,
   parameter bit          DIG_ACTIVE_LOW = 1'b1
)(
   input  logic                  clk,
   input  logic                  reset,
   input  logic [DATA_W-1:0]     data_in,
   input  logic                  enable,
   input  logic                  lz_suppress,
   output logic [SEG_W-1:0]      seg,
   output logic [NUM_DIGITS-1:0] dig,
   output logic                  frame_tick
);

   localparam int unsigned          CNT_W     = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam logic [CNT_W-1:0]      CNT_MAX   = CNT_W'(SCAN_DIV - 1);
   localparam logic [CNT_W-1:0]      BLANK_CNT = CNT_W'(BLANK_CYCLES);
   localparam logic [IDX_W-1:0]      IDX_LAST  = IDX_W'(NUM_DIGITS - 1);
   localparam logic [SEG_W-1:0]      SEG_OFF   = SEG_ACTIVE_LOW ? '1 : '0;
   localparam logic [NUM_DIGITS-1:0] DIG_OFF   = DIG_ACTIVE_LOW ? '1 : '0;

   logic [CNT_W-1:0]      r_cnt;
   logic [IDX_W-1:0]      r_idx;
   logic [DATA_W-1:0]     r_frame;
   logic [SEG_W-1:0]      r_seg;
   logic [NUM_DIGITS-1:0] r_dig;
   logic                  r_frame_tick;

   logic [CNT_W-1:0]      w_cnt_n;
   logic [IDX_W-1:0]      w_idx_n;
   logic [DATA_W-1:0]     w_frame_n;
   logic                  w_tick_n;
   phase_e                w_phase;
   logic                  w_hi_zero;
   logic                  w_blank;
   logic [NIB_W-1:0]      w_nibble;
   logic [SEG_W-1:0]      w_font_c;
   logic [SEG_W-1:0]      w_seg_n;
   logic [NUM_DIGITS-1:0] w_dig_n;

   // State and output registers; outputs follow the state loaded on the same edge.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_cnt        <= CNT_MAX;
         r_idx        <= IDX_LAST;
         r_frame      <= '0;
         r_seg        <= SEG_OFF;
         r_dig        <= DIG_OFF;
         r_frame_tick <= 1'b0;
      end else begin
         r_cnt        <= w_cnt_n;
         r_idx        <= w_idx_n;
         r_frame      <= w_frame_n;
         r_seg        <= w_seg_n;
         r_dig        <= w_dig_n;
         r_frame_tick <= w_tick_n;
      end
   end

   // Slot counter / digit index advance; latch a new frame when digit 3 wraps to 0.
   always_comb begin
      w_cnt_n   = r_cnt;
      w_idx_n   = r_idx;
      w_frame_n = r_frame;
      w_tick_n  = 1'b0;
      if (!enable) begin
         w_cnt_n   = CNT_MAX;
         w_idx_n   = IDX_LAST;
         w_frame_n = '0;
      end else if (r_cnt < CNT_MAX) begin
         w_cnt_n = r_cnt + CNT_W'(1);
      end else begin
         w_cnt_n = '0;
         w_idx_n = r_idx + IDX_W'(1);
         if (r_idx == IDX_LAST) begin
            w_frame_n = data_in;
            w_tick_n  = 1'b1;
         end
      end
   end

   // Phase, leading-zero detection and digit-select for the upcoming state.
   always_comb begin
      w_phase   = PH_BLANK;
      w_hi_zero = 1'b0;
      if (enable && (w_cnt_n >= BLANK_CNT)) begin
         w_phase = PH_SHOW;
      end
      case (w_idx_n)
         2'd3:    w_hi_zero = (w_frame_n[15:12] == 4'h0);
         2'd2:    w_hi_zero = (w_frame_n[15:8]  == 8'h00);
         2'd1:    w_hi_zero = (w_frame_n[15:4]  == 12'h000);
         default: w_hi_zero = 1'b0;
      endcase
      w_blank  = (w_phase == PH_BLANK) || (lz_suppress && w_hi_zero);
      w_nibble = w_frame_n[{w_idx_n, 2'b00} +: NIB_W];
      w_dig_n  = dig_drive(w_blank ? '0 : (NUM_DIGITS'(1) << w_idx_n), DIG_ACTIVE_LOW);
      w_seg_n  = seg_drive(w_font_c, SEG_ACTIVE_LOW);
   end

   d7seg_hex_decode u_hex_decode (
      .i_nibble (w_nibble),
      .i_blank  (w_blank),
      .o_seg_c  (w_font_c)
   );

   assign seg        = r_seg;
   assign dig        = r_dig;
   assign frame_tick = r_frame_tick;

endmodule

// File: tb/tb_d7seg_scan_driver.sv
// Directed bench for d7seg_scan_driver with SCAN_DIV=8, BLANK_CYCLES=2.
module tb_d7seg_scan_driver;

   logic        clk;
   logic        reset;
   logic [15:0] data_in;
   logic        enable;
   logic        lz_suppress;
   logic [6:0]  seg;
   logic [3:0]  dig;
   logic        frame_tick;

   int n_checks = 0;
   int n_pass   = 0;

   localparam logic [3:0] D0 = 4'b1110;
   localparam logic [3:0] D1 = 4'b1101;
   localparam logic [3:0] D2 = 4'b1011;
   localparam logic [3:0] D3 = 4'b0111;
   localparam logic [3:0] DOFF = 4'hF;
   localparam logic [6:0] SOFF = 7'h7F;

   d7seg_scan_driver #(
      .SCAN_DIV     (8),
      .BLANK_CYCLES (2)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .data_in     (data_in),
      .enable      (enable),
      .lz_suppress (lz_suppress),
      .seg         (seg),
      .dig         (dig),
      .frame_tick  (frame_tick)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Count one comparison and report a mismatch.
   task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   // Advance one active edge; land on the following falling edge to sample.
   task automatic step();
      @(negedge clk);
   endtask

   // Check the off state on all outputs.
   task automatic check_off(input string tag, input logic exp_tick);
      check({tag, "_seg"},  16'(seg),        16'(SOFF));
      check({tag, "_dig"},  16'(dig),        16'(DOFF));
      check({tag, "_tick"}, 16'(frame_tick), 16'(exp_tick));
   endtask

   // Walk a full 32-cycle frame starting just after its latch edge.
   // At position chg_at the inputs are updated after sampling.
   task automatic check_frame(input string tag,
                              input logic [6:0] s0, input logic [6:0] s1,
                              input logic [6:0] s2, input logic [6:0] s3,
                              input logic [3:0] d0, input logic [3:0] d1,
                              input logic [3:0] d2, input logic [3:0] d3,
                              input int chg_at, input logic [15:0] chg_data,
                              input logic chg_lz);
      logic [6:0] s [4];
      logic [3:0] d [4];
      s[0] = s0; s[1] = s1; s[2] = s2; s[3] = s3;
      d[0] = d0; d[1] = d1; d[2] = d2; d[3] = d3;
      for (int p = 0; p < 32; p++) begin
         int k;
         int c;
         k = p / 8;
         c = p % 8;
         check($sformatf("%s_p%0d_tick", tag, p), 16'(frame_tick), (p == 0) ? 16'd1 : 16'd0);
         if (c < 2) begin
            check($sformatf("%s_p%0d_seg", tag, p), 16'(seg), 16'(SOFF));
            check($sformatf("%s_p%0d_dig", tag, p), 16'(dig), 16'(DOFF));
         end else begin
            check($sformatf("%s_p%0d_seg", tag, p), 16'(seg), 16'(s[k]));
            check($sformatf("%s_p%0d_dig", tag, p), 16'(dig), 16'(d[k]));
         end
         if (p == chg_at) begin
            data_in     = chg_data;
            lz_suppress = chg_lz;
         end
         step();
      end
   endtask

   initial begin
      reset       = 1'b1;
      enable      = 1'b1;
      lz_suppress = 1'b0;
      data_in     = 16'h1234;

      // Reset held with enable high
      step();
      step();
      check_off("rst_hold", 1'b0);
      reset = 1'b0;
      step();
      check_off("rst_first", 1'b1);

      // Basic scan of 1234, then a change to ABCD during digit 1 of the next frame
      check_frame("basic", 7'h19, 7'h30, 7'h24, 7'h79, D0, D1, D2, D3, -1, 16'h1234, 1'b0);
      check_frame("nomid", 7'h19, 7'h30, 7'h24, 7'h79, D0, D1, D2, D3, 10, 16'hABCD, 1'b0);
      check_frame("abcd",  7'h21, 7'h46, 7'h03, 7'h08, D0, D1, D2, D3, 31, 16'h0005, 1'b1);

      // Leading-zero suppression
      check_frame("lz5",   7'h12, SOFF, SOFF, SOFF, D0, DOFF, DOFF, DOFF, 31, 16'h0000, 1'b1);
      check_frame("lz0",   7'h40, SOFF, SOFF, SOFF, D0, DOFF, DOFF, DOFF, 31, 16'h00F0, 1'b1);
      check_frame("lzf0",  7'h40, 7'h0E, SOFF, SOFF, D0, D1, DOFF, DOFF, 31, 16'h1234, 1'b0);

      // Enable drop mid-SHOW of digit 2
      repeat (19) step();
      check("en_pre_seg", 16'(seg), 16'(7'h24));
      check("en_pre_dig", 16'(dig), 16'(D2));
      enable = 1'b0;
      step();
      check_off("en_off1", 1'b0);
      step();
      check_off("en_off2", 1'b0);
      data_in = 16'h5678;
      enable  = 1'b1;
      step();
      check_frame("reen",  7'h00, 7'h78, 7'h02, 7'h12, D0, D1, D2, D3, -1, 16'h5678, 1'b0);

      // Asynchronous reset mid-SHOW of digit 2
      repeat (19) step();
      check("mr_pre_seg", 16'(seg), 16'(7'h02));
      check("mr_pre_dig", 16'(dig), 16'(D2));
      reset = 1'b1;
      #1;
      check_off("mr_async", 1'b0);
      check("mr_frame", dut.r_frame, 16'h0000);
      step();
      check_off("mr_hold", 1'b0);
      reset   = 1'b0;
      data_in = 16'h000D;
      step();
      check_off("mr_first", 1'b1);
      step();
      check_off("mr_blank", 1'b0);
      step();
      check("mr_show_seg", 16'(seg), 16'(7'h21));
      check("mr_show_dig", 16'(dig), 16'(D0));

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
